// File: rtl/data_mem_lsu.sv
// Load/store unit between the execute stage and a byte-addressed data RAM.
// One request in flight; IDLE -> ACCESS -> RESP, with faulting requests going straight to RESP.
module data_mem_lsu #(
  parameter int ADDR_W        = 16,
  parameter int MEM_BYTES     = 65536,
  parameter bit MISALIGN_TRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        ram_re,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [31:0]       ram_w_data,
  input  logic [31:0]       ram_r_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t              state, state_nxt;
  logic                lat_we;
  logic [2:0]          lat_f3;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [2:0]          req_nbytes;
  logic [32:0]         req_end;
  logic                req_illegal;
  logic                req_misaligned;
  logic                req_fault;
  logic [3:0]          strb;
  logic [31:0]         load_data;

  // Request decode; the end address is formed at 33 bits so addresses near 2^32 cannot wrap.
  // NOTE: every combinational output gets a value on every path (case default), so no latch is inferred.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    req_end        = {1'b0, req_addr} + {30'b0, req_nbytes};
    req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_fault      = req_illegal || (req_end > MEM_LIMIT) || (MISALIGN_TRAP && req_misaligned);
  end

  always_comb begin
    case (lat_f3[1:0])
      2'b00:   strb = 4'b0001;
      2'b01:   strb = 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // The RAM sign-extends narrow reads, so only the unsigned loads need fixing up here.
  always_comb begin
    case (lat_f3)
      3'b100:  load_data = {24'b0, ram_r_data[7:0]};
      3'b101:  load_data = {16'b0, ram_r_data[15:0]};
      default: load_data = ram_r_data;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_fault ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr[ADDR_W-1:0];
        lat_wdata <= req_wdata;
        rdata_q   <= '0;
        err_q     <= req_fault;
      end
      if (state == ACCESS) rdata_q <= lat_we ? '0 : load_data;
    end
  end

  // Strobes decode straight from state, so an asynchronous reset in ACCESS drops them at once.
  assign ram_re     = (state == ACCESS && !lat_we) ? strb : 4'b0000;
  assign ram_we     = (state == ACCESS &&  lat_we) ? strb : 4'b0000;
  assign ram_r_addr = lat_addr;
  assign ram_w_addr = lat_addr;
  assign ram_w_data = lat_wdata;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: byte RAM model, shadow-memory scoreboard, and a second
// instance built with misalignment trapping for the fault cases.
module tb_data_mem_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  ram_re, ram_we;
  logic [15:0] ram_r_addr, ram_w_addr;
  logic [31:0] ram_w_data, ram_r_data;

  logic        t_req_valid, t_req_ready, t_req_we;
  logic [2:0]  t_req_funct3;
  logic [31:0] t_req_addr, t_req_wdata;
  logic        t_resp_valid, t_resp_ready, t_resp_err;
  logic [31:0] t_resp_rdata;
  logic [3:0]  t_ram_re, t_ram_we;
  logic [15:0] t_ram_r_addr, t_ram_w_addr;
  logic [31:0] t_ram_w_data, t_ram_r_data;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [7:0]  rb0, rb1, rb2, rb3;
  exp_t        exp_q[$];
  int          n_checks, n_errors;
  int          re_cycles, we_cycles, both_cycles;

  data_mem_lsu #(.ADDR_W(16), .MEM_BYTES(65536), .MISALIGN_TRAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_re(ram_re), .ram_we(ram_we), .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  data_mem_lsu #(.ADDR_W(16), .MEM_BYTES(65536), .MISALIGN_TRAP(1'b1)) dut_trap (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
    .req_funct3(t_req_funct3), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .ram_re(t_ram_re), .ram_we(t_ram_we), .ram_r_addr(t_ram_r_addr), .ram_w_addr(t_ram_w_addr),
    .ram_w_data(t_ram_w_data), .ram_r_data(t_ram_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational sign-extending read, byte writes on the falling edge.
  assign rb0 = mem[ram_r_addr];
  assign rb1 = mem[ram_r_addr + 16'd1];
  assign rb2 = mem[ram_r_addr + 16'd2];
  assign rb3 = mem[ram_r_addr + 16'd3];

  always_comb begin
    case (ram_re)
      4'b0001: ram_r_data = {{24{rb0[7]}}, rb0};
      4'b0011: ram_r_data = {{16{rb1[7]}}, rb1, rb0};
      4'b1111: ram_r_data = {rb3, rb2, rb1, rb0};
      default: ram_r_data = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_w_addr + 16'(i)] <= ram_w_data[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of LSU+RAM; stores update the shadow image.
  function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int          nb;
    logic [32:0] endp;
    logic [31:0] w;
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endp = {1'b0, addr} + 33'(nb);
    err  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]) || (endp > 33'd65536);
    rd   = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) shadow[16'(addr + 32'(i))] = wdata[8*i +: 8];
      end else begin
        w = {shadow[16'(addr + 32'd3)], shadow[16'(addr + 32'd2)],
             shadow[16'(addr + 32'd1)], shadow[16'(addr)]};
        case (f3)
          3'b000:  rd = {{24{w[7]}}, w[7:0]};
          3'b001:  rd = {{16{w[15]}}, w[15:0]};
          3'b100:  rd = {24'b0, w[7:0]};
          3'b101:  rd = {16'b0, w[15:0]};
          default: rd = w;
        endcase
      end
    end
  endfunction

  always @(negedge clk) begin
    if (ram_re != 4'b0) re_cycles++;
    if (ram_we != 4'b0) we_cycles++;
    if (ram_re != 4'b0 && ram_we != 4'b0) both_cycles++;
  end

  // Scoreboard: pop on each response handshake.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  // Called and returns on a falling edge with the DUT idle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold = 0);
    int          n, re0, we0;
    logic [3:0]  strb;
    logic [31:0] dummy_rd;
    logic        dummy_err;
    strb = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    model_access(we, f3, addr, wdata, dummy_rd, dummy_err);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    resp_ready = (hold == 0);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 16) begin @(negedge clk); n++; end
    check("req_ready", {31'b0, req_ready}, 32'h1);
    re0 = re_cycles; we0 = we_cycles;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!resp_valid && n < 8) begin
      check("ram_re", {28'b0, ram_re}, we ? 32'h0 : {28'b0, strb});
      check("ram_we", {28'b0, ram_we}, we ? {28'b0, strb} : 32'h0);
      check("ram_addr", {ram_r_addr, ram_w_addr}, {addr[15:0], addr[15:0]});
      if (we) check("ram_wdata", ram_w_data, wdata);
      @(negedge clk); n++;
    end
    check("latency", n, exp_err ? 32'd1 : 32'd2);
    check("re_cycles", re_cycles - re0, (!we && !exp_err) ? 32'd1 : 32'd0);
    check("we_cycles", we_cycles - we0, (we && !exp_err) ? 32'd1 : 32'd0);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", {31'b0, resp_valid}, 32'h1);
        check("hold_rdata", resp_rdata, exp_rdata);
        check("hold_err", {31'b0, resp_err}, {31'b0, exp_err});
        check("hold_req_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    check("back_idle", {30'b0, resp_valid, req_ready}, 32'h1);
  endtask

  task automatic trap_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic exp_err, input logic [31:0] exp_rdata);
    t_req_we = we; t_req_funct3 = f3; t_req_addr = addr; t_req_wdata = 32'hA5A5_5A5A;
    t_req_valid = 1'b1;
    @(posedge clk); #1 t_req_valid = 1'b0;
    @(negedge clk);
    if (!exp_err) begin
      check("trap_in_access", {31'b0, t_resp_valid}, 32'h0);
      @(negedge clk);
    end
    check("trap_valid", {31'b0, t_resp_valid}, 32'h1);
    check("trap_err", {31'b0, t_resp_err}, {31'b0, exp_err});
    check("trap_rdata", t_resp_rdata, exp_rdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        r_we, r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd, r_rd;
    logic [2:0]  f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    n_checks = 0; n_errors = 0; re_cycles = 0; we_cycles = 0; both_cycles = 0;
    foreach (mem[i]) begin mem[i] = 8'h0; shadow[i] = 8'h0; end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = 3'b0; t_req_addr = 32'h0;
    t_req_wdata = 32'h0; t_resp_ready = 1'b1; t_ram_r_data = 32'h8765_4321;

    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_strobes", {24'b0, ram_re, ram_we}, 32'h0);
    check("rst_addr", {ram_r_addr, ram_w_addr}, 32'h0);
    check("rst_wdata", ram_w_data, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // Word store then load back.
    issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte/halfword sign and zero extension.
    issue(1'b1, 3'b000, 32'h200, 32'h0000_0080, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h201, 32'h0000_00FF, 32'h0, 1'b0);
    issue(1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b100, 32'h200, 32'h0, 32'h0000_0080, 1'b0);
    issue(1'b0, 3'b001, 32'h200, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b101, 32'h200, 32'h0, 32'h0000_FF80, 1'b0);

    // Byte store leaves its neighbours alone.
    issue(1'b1, 3'b010, 32'h300, 32'hAABB_CCDD, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'hAABB_78DD, 1'b0);
    issue(1'b1, 3'b001, 32'h302, 32'h0000_9911, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h9911_78DD, 1'b0);

    // Range and encoding faults, plus the legal accesses right at the top of memory.
    issue(1'b0, 3'b010, 32'h0000_FFFE, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h0000_FFFF, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h0000_FFFC, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h0000_FFFF, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h100, 32'h0000_0011, 32'h0, 1'b1);
    issue(1'b1, 3'b101, 32'h100, 32'h0000_0011, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Misaligned accesses are legal without trapping.
    issue(1'b0, 3'b010, 32'h102, 32'h0, 32'h0000_DEAD, 1'b0);
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFF_ADBE, 1'b0);

    // Consumer stalls the response.
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

    // Reset in ACCESS drops a store before it reaches the RAM.
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    check("pre_rst_we", {28'b0, ram_we}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("rst_access_strobes", {24'b0, ram_re, ram_we}, 32'h0);
    check("rst_access_state", {30'b0, req_ready, resp_valid}, 32'h2);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b0);

    // Random traffic in a small window, checked against the shadow image.
    for (int k = 0; k < 16; k++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = f3_tab[$urandom_range(0, 5)];
      r_addr = 32'h500 + 32'($urandom_range(0, 15));
      r_wd   = $urandom();
      model_access(r_we, r_f3, r_addr, r_wd, r_rd, r_err);
      issue(r_we, r_f3, r_addr, r_wd, r_rd, r_err);
    end

    // Misalignment trapping instance.
    trap_req(1'b0, 3'b010, 32'h102, 1'b1, 32'h0);
    trap_req(1'b0, 3'b001, 32'h101, 1'b1, 32'h0);
    trap_req(1'b1, 3'b010, 32'h103, 1'b1, 32'h0);
    trap_req(1'b0, 3'b010, 32'h104, 1'b0, 32'h8765_4321);
    trap_req(1'b0, 3'b101, 32'h102, 1'b0, 32'h0000_4321);
    trap_req(1'b0, 3'b000, 32'h103, 1'b0, 32'h8765_4321);

    check("both_strobes", both_cycles, 32'h0);
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
